demux_1_2_stream: RTL
=====================

Name: demux_1_2_stream

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes; it is the inverse of the 2:1 datapath mux.
- Takes one 32-bit stream plus a select bit and routes each word to output A (sel=0) or output B (sel=1) through a single holding register.
- Sits between a single producer and two consumers, for example result steering toward two downstream stages.
- Sustains one word per cycle with 1-cycle latency.

Parameters:
- WIDTH, 32, data width of input and both outputs.
- CNT_W, 16, width of the per-channel transfer counters (used only with DEMUX_CNT_EN).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- i_data  in  WIDTH  input word.
- i_sel  in  1  destination select: 0 routes to A, 1 routes to B.
- i_valid  in  1  input word valid.
- i_ready  out  1  block can accept a word this cycle.
- out_a  out  WIDTH  channel A data.
- a_valid  out  1  channel A word valid.
- a_ready  in  1  channel A consumer accepts.
- out_b  out  WIDTH  channel B data.
- b_valid  out  1  channel B word valid.
- b_ready  in  1  channel B consumer accepts.
- cnt_a  out  CNT_W  words delivered on A (DEMUX_CNT_EN only).
- cnt_b  out  CNT_W  words delivered on B (DEMUX_CNT_EN only).

Behaviour:
- Internal state:
  - hold_data[WIDTH], hold_sel, and a 2-state FSM, EMPTY / FULL, where FULL means hold is valid.
- Reset (async, rst=1), effective immediately and independent of clk:
  - FSM goes to EMPTY; hold_data=0; hold_sel=0.
  - Therefore a_valid=0, b_valid=0, out_a=0, out_b=0, i_ready=1, and cnt_a=cnt_b=0.
  - Reset mid-transfer discards the held word; no delivery is counted for it.
- Outputs (combinational from state):
  - a_valid = FULL & ~hold_sel; b_valid = FULL & hold_sel.
  - out_a = hold_data when a_valid, else 0. out_b = hold_data when b_valid, else 0.
  - The unselected output is always 0.
- Drain and ready:
  - drain = (a_valid & a_ready) | (b_valid & b_ready).
  - i_ready = EMPTY | drain. This is a combinational path from a_ready/b_ready to i_ready, and is intended.
- Accept:
  - accept = i_valid & i_ready.
  - On accept, hold_data<=i_data and hold_sel<=i_sel at the next rising edge.
- Transitions:
  - EMPTY + accept -> FULL.
  - EMPTY + no accept -> EMPTY; hold_data and hold_sel are unchanged.
  - FULL + drain + accept -> FULL, loaded with the new word (back-to-back, 1 word/cycle).
  - FULL + drain + no accept -> EMPTY.
  - FULL + no drain -> FULL; hold_data and hold_sel are held stable. i_ready=0, so a valid input stalls.
- Latency:
  - A word accepted at edge N is presented on its output after edge N, and can be consumed in the cycle following acceptance.
- Ordering and blocking:
  - Strict in-order delivery.
  - A stalled word for A blocks later words for B (head-of-line blocking is intended).
- Ready independence:
  - a_ready/b_ready of the unselected channel have no effect.
  - The ready inputs may be high when the matching valid is low; that is not a transfer.
- Valid stability:
  - Once a_valid/b_valid rises, data and select remain stable until the transfer completes or reset asserts.
- i_sel with i_valid=0 is ignored.

Optional Feature:
- Macro DEMUX_CNT_EN.
- Defined:
  - cnt_a increments by 1 on each cycle with a_valid & a_ready; cnt_b likewise with b_valid & b_ready.
  - Both wrap modulo 2^CNT_W (0xFFFF -> 0x0000 at default width).
  - Both reset to 0 on rst.
- Undefined:
  - Counters and their ports are removed. cnt_a/cnt_b do not exist.
  - Datapath behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with hold FULL (i_data=59, sel=0) -> a_valid=0, out_a=0, i_ready=1 immediately, with no clock edge required.
- Basic routing: i_data=59, i_sel=0, i_valid=1 for one cycle, a_ready=1 -> after the next edge a_valid=1 and out_a=59, out_b=0; the next edge returns to EMPTY. Repeat with i_data=133, i_sel=1 -> b_valid=1, out_b=133, out_a=0.
- Back-to-back alternating: stream 59/A, 133/B, 7/A, 9/B on consecutive cycles with both readies high -> one delivery per cycle in order, i_ready held at 1 throughout.
- Backpressure: hold 133/B with b_ready=0 for 5 cycles while i_valid=1 (next word 59/A) -> i_ready=0, out_b stays 133, a_valid=0. Raise b_ready -> 133 is consumed, and 59 loads on the same edge and appears on A.
- Wrong-channel ready: hold 59/A with a_ready=0, b_ready=1 -> no transfer, state stays FULL, i_ready=0.
- DEMUX_CNT_EN: deliver 3 words to A and 2 to B -> cnt_a=3, cnt_b=2. With cnt_a preloaded to 0xFFFF via 65535 A transfers, one more transfer -> cnt_a=0.

Source files
------------

// File: rtl/demux_1_2_stream.sv
// Registered 1-to-2 stream demultiplexer: one holding register steers each word to channel A or B.
// Optional per-channel delivery counters are enabled by defining DEMUX_CNT_EN.
module demux_1_2_stream #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_sel,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] out_a,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             b_valid,
  input  logic             b_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hold_data_p0;
  logic             hold_sel_p0;
  logic             drain;
  logic             accept;

  always_comb begin
    a_valid   = (state == FULL) && !hold_sel_p0;
    b_valid   = (state == FULL) && hold_sel_p0;
    out_a     = a_valid ? hold_data_p0 : '0;
    out_b     = b_valid ? hold_data_p0 : '0;
    drain     = (a_valid && a_ready) || (b_valid && b_ready);
    i_ready   = (state == EMPTY) || drain;
    accept    = i_valid && i_ready;
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (drain && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Stage p0: holding register, reloaded only on an accepted word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data_p0 <= '0;
      hold_sel_p0  <= 1'b0;
    end else if (accept) begin
      hold_data_p0 <= i_data;
      hold_sel_p0  <= i_sel;
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_valid && a_ready) cnt_a <= cnt_a + 1'b1;
      if (b_valid && b_ready) cnt_b <= cnt_b + 1'b1;
    end
  end
`endif

endmodule
